conv3x3_filter: RTL
===================

CONV3X3_FILTER -- requirements
Module: conv3x3_filter

Interface
REQ-001 SHALL have parameter: PIX_W, 8, pixel width in bits.
REQ-002 SHALL have parameter: FRAME_PIXELS, 4096, output pixels per frame (64x64).
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  window on pixelr1..pixelr9 valid this cycle.
REQ-006 SHALL have ports: pixelr1..pixelr9  input  PIX_W each  3x3 window, row-major (1 top-left, 5 centre, 9 bottom-right).
REQ-007 SHALL have port: pixelw  output  PIX_W  filtered pixel.
REQ-008 SHALL have port: wr  output  1  pixelw valid; drives the write strobe of the frame store.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse with the last pixel of a frame.
REQ-010 SHALL have port: pix_cnt  output  12  number of pixels already output in the current frame.

Function
REQ-011 SHALL compute a Gaussian kernel [1 2 1; 2 4 2; 1 2 1]: sum = p1+2p2+p3+2p4+4p5+2p6+p7+2p8+p9, 12-bit unsigned, never overflowing (max 4080).
REQ-012 SHALL round: result = (sum + 8) >> 4, computed in 13 bits; result is always <= 255, so no saturation logic.
REQ-013 SHALL be a 3-stage pipeline: S1 registers the three weighted row sums; S2 registers the total sum; S3 registers the rounded result into pixelw.
REQ-014 SHALL have fixed latency: a window with in_valid=1 at edge N appears on pixelw with wr=1 after edge N+3.
REQ-015 SHALL carry a valid bit with every stage; in_valid=0 cycles propagate as bubbles; there is no stall and no backpressure.
REQ-016 SHALL hold pixelw at its last value while wr=0; pixelw is not cleared on bubbles.
REQ-017 SHALL increment pix_cnt on every wr=1 cycle.
REQ-018 SHALL, on the wr=1 cycle where pix_cnt==FRAME_PIXELS-1, assert frame_done for exactly that cycle and wrap pix_cnt to 0 at the next edge.
REQ-019 SHALL accept back-to-back windows on every cycle, giving a throughput of one pixel per clock.
REQ-020 SHALL take no action on in_valid while the inputs are X; only valid-qualified data affects state other than the datapath registers.

Reset
REQ-021 SHALL, while rst_n=0, force pixelw=0, wr=0, frame_done=0, pix_cnt=0, all stage valid bits=0, and all datapath registers=0.
REQ-022 SHALL discard all in-flight windows when rst_n is asserted mid-operation; no wr pulse is produced for them after release.
REQ-023 SHALL have its first valid output, after rst_n deasserts, come from a window sampled at or after the first rising edge following deassertion.

Configuration
REQ-024 SHALL, when macro CONV_THRESH_EN is defined, add port thresh (input, PIX_W, binarisation level) and replace S3 output with 255 if result >= thresh else 0, at the same latency.
REQ-025 SHALL, when CONV_THRESH_EN is undefined, not have the thresh port, and pixelw SHALL equal the rounded Gaussian result.

Verification
REQ-026 SHALL cover: all nine inputs=100, in_valid for 1 cycle -> wr=1 exactly 3 cycles later, pixelw=100.
REQ-027 SHALL cover: p5=255, others 0 -> pixelw=64 (sum 1020, (1020+8)>>4); all inputs 255 -> pixelw=255.
REQ-028 SHALL cover: in_valid pattern 1,0,1,1 -> wr pattern 1,0,1,1 delayed by 3 cycles, with pix_cnt incremented by 3.
REQ-029 SHALL cover: 4096 valid windows -> frame_done high only with the 4096th wr, then pix_cnt=0; the 4097th output gives pix_cnt=1 afterwards.
REQ-030 SHALL cover: rst_n pulsed low with 2 windows in flight -> wr stays 0 and pix_cnt=0, and no stale output after release.
REQ-031 SHALL cover, with CONV_THRESH_EN defined: p5=255, others 0, thresh=64 -> pixelw=255; thresh=65 -> pixelw=0.

Source files
------------

// File: rtl/conv3x3_filter.sv
// 3x3 Gaussian filter [1 2 1;2 4 2;1 2 1] with rounding; optional binarisation under CONV_THRESH_EN.
// Latency 3 cycles (row sums, total, rounded result); one window per clock, no stall/backpressure.
module conv3x3_filter #(
  parameter int PIX_W        = 8,
  parameter int FRAME_PIXELS = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] pixelr1,
  input  logic [PIX_W-1:0] pixelr2,
  input  logic [PIX_W-1:0] pixelr3,
  input  logic [PIX_W-1:0] pixelr4,
  input  logic [PIX_W-1:0] pixelr5,
  input  logic [PIX_W-1:0] pixelr6,
  input  logic [PIX_W-1:0] pixelr7,
  input  logic [PIX_W-1:0] pixelr8,
  input  logic [PIX_W-1:0] pixelr9,
  output logic [PIX_W-1:0] pixelw,
  output logic             wr,
  output logic             frame_done,
  output logic [11:0]      pix_cnt
`ifdef CONV_THRESH_EN
  ,
  input  logic [PIX_W-1:0] thresh
`endif
);

  localparam int SUM_W = PIX_W + 4;
  localparam logic [11:0] LAST_CNT = 12'(FRAME_PIXELS - 1);

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             wr_q, wr_d;
  logic [SUM_W-1:0] row1_q, row1_d;
  logic [SUM_W-1:0] row2_q, row2_d;
  logic [SUM_W-1:0] row3_q, row3_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   rnd;
  logic [PIX_W-1:0] res;
  logic [PIX_W-1:0] pix_out;
  logic [PIX_W-1:0] pixelw_q, pixelw_d;
  logic [11:0]      pix_cnt_q, pix_cnt_d;

  always_comb begin
    v1_d   = in_valid;
    row1_d = row1_q;
    row2_d = row2_q;
    row3_d = row3_q;
    // Datapath registers only load on valid data, so bubbles leave them untouched.
    if (in_valid) begin
      row1_d = SUM_W'(pixelr1) + (SUM_W'(pixelr2) << 1) + SUM_W'(pixelr3);
      row2_d = (SUM_W'(pixelr4) << 1) + (SUM_W'(pixelr5) << 2) + (SUM_W'(pixelr6) << 1);
      row3_d = SUM_W'(pixelr7) + (SUM_W'(pixelr8) << 1) + SUM_W'(pixelr9);
    end

    v2_d  = v1_q;
    sum_d = sum_q;
    if (v1_q) begin
      sum_d = row1_q + row2_q + row3_q;
    end

    rnd = {1'b0, sum_q} + (SUM_W + 1)'(8);
    res = PIX_W'(rnd >> 4);
`ifdef CONV_THRESH_EN
    pix_out = (res >= thresh) ? '1 : '0;
`else
    pix_out = res;
`endif

    wr_d     = v2_q;
    pixelw_d = pixelw_q;
    if (v2_q) begin
      pixelw_d = pix_out;
    end

    pix_cnt_d = pix_cnt_q;
    if (wr_q) begin
      pix_cnt_d = (pix_cnt_q == LAST_CNT) ? 12'd0 : pix_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wr_q      <= 1'b0;
      row1_q    <= '0;
      row2_q    <= '0;
      row3_q    <= '0;
      sum_q     <= '0;
      pixelw_q  <= '0;
      pix_cnt_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      wr_q      <= wr_d;
      row1_q    <= row1_d;
      row2_q    <= row2_d;
      row3_q    <= row3_d;
      sum_q     <= sum_d;
      pixelw_q  <= pixelw_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  assign pixelw     = pixelw_q;
  assign wr         = wr_q;
  assign pix_cnt    = pix_cnt_q;
  assign frame_done = wr_q && (pix_cnt_q == LAST_CNT);

endmodule
